// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline front end.
package cpu_pkg;

   localparam int PC_W   = 64;
   localparam int INSN_W = 32;

   localparam logic [PC_W-1:0]   PC_INC   = 64'd4;
   localparam logic [INSN_W-1:0] NOP_INSN = 32'hD503_201F;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
      return pc + PC_INC;
   endfunction

   function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry parking slot for an instruction that returned while decode was stalled.
module fetch_hold_buf
   import cpu_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [INSN_W-1:0] i_insn,
   output logic              o_valid,
   output logic [PC_W-1:0]   o_pc,
   output logic [INSN_W-1:0] o_insn
);

   logic              r_valid;
   logic [PC_W-1:0]   r_pc;
   logic [INSN_W-1:0] r_insn;

   // Clear wins over load so a redirect always empties the slot.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_valid <= 1'b0;
         r_pc    <= {PC_W{1'b0}};
         r_insn  <= NOP_INSN;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_insn  <= i_insn;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_insn  = r_insn;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and fills IF/ID,
// honouring decode stall and EX redirect.
module fetch_unit
   import cpu_pkg::*;
(
   input  logic              CLK,
   input  logic              reset,
   input  logic [PC_W-1:0]   startpc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INSN_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              stall,
   output logic              ifid_valid,
   output logic [PC_W-1:0]   ifid_pc,
   output logic [INSN_W-1:0] ifid_insn,
   output logic [PC_W-1:0]   currentpc,
   output logic              misalign
);

   fetch_state_t      r_state;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_drain_addr;
   logic              r_ifid_valid;
   logic [PC_W-1:0]   r_ifid_pc;
   logic [INSN_W-1:0] r_ifid_insn;
   logic              r_misalign;

   logic              w_accept;
   logic              w_req;
   logic [PC_W-1:0]   w_addr;
   logic              w_got;
   logic              w_buf_load;
   logic              w_buf_clear;
   logic              w_buf_valid;
   logic [PC_W-1:0]   w_buf_pc;
   logic [INSN_W-1:0] w_buf_insn;

   // Request/address decode; DRAIN keeps presenting the abandoned address until it is acked.
   always_comb begin
      w_accept = !(r_ifid_valid && stall);
      w_req    = 1'b0;
      w_addr   = r_pc;
      if (reset) begin
         w_req = 1'b0;
      end else begin
         case (r_state)
            FETCH:   w_req = w_accept && !redirect;
            WAIT:    w_req = 1'b1;
            HOLD:    w_req = 1'b0;
            DRAIN: begin
               w_req  = 1'b1;
               w_addr = r_drain_addr;
            end
            default: w_req = 1'b0;
         endcase
      end
      w_got       = w_req && imem_ack;
      w_buf_load  = (r_state == WAIT) && w_got && !w_accept && !redirect;
      w_buf_clear = redirect || ((r_state == HOLD) && w_accept);
   end

   fetch_hold_buf u_hold_buf (
      .i_clk   (CLK),
      .i_reset (reset),
      .i_load  (w_buf_load),
      .i_clear (w_buf_clear),
      .i_pc    (r_pc),
      .i_insn  (imem_rdata),
      .o_valid (w_buf_valid),
      .o_pc    (w_buf_pc),
      .o_insn  (w_buf_insn)
   );

   // PC, fetch FSM and IF/ID register; redirect outranks stall and every state.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state      <= FETCH;
         r_pc         <= startpc;
         r_drain_addr <= {PC_W{1'b0}};
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= {PC_W{1'b0}};
         r_ifid_insn  <= {INSN_W{1'b0}};
         r_misalign   <= 1'b0;
      end else if (redirect) begin
         r_pc         <= redirect_pc;
         r_ifid_valid <= 1'b0;
         r_misalign   <= r_misalign | is_misaligned(redirect_pc);
         // An unanswered request must still be retired before refetching.
         if (w_req && !imem_ack) begin
            r_state      <= DRAIN;
            r_drain_addr <= w_addr;
         end else begin
            r_state <= FETCH;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (w_got) begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_pc    <= r_pc;
                  r_ifid_insn  <= imem_rdata;
                  r_pc         <= pc_next(r_pc);
               end else if (w_req) begin
                  r_state <= WAIT;
               end else begin
                  r_state <= FETCH;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  r_pc <= pc_next(r_pc);
                  if (w_accept) begin
                     r_ifid_valid <= 1'b1;
                     r_ifid_pc    <= r_pc;
                     r_ifid_insn  <= imem_rdata;
                     r_state      <= FETCH;
                  end else begin
                     r_state <= HOLD;
                  end
               end else begin
                  r_state <= WAIT;
               end
            end
            HOLD: begin
               if (w_accept && w_buf_valid) begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_pc    <= w_buf_pc;
                  r_ifid_insn  <= w_buf_insn;
                  r_state      <= FETCH;
               end else begin
                  r_state <= HOLD;
               end
            end
            DRAIN: begin
               if (imem_ack) begin
                  r_state <= FETCH;
               end else begin
                  r_state <= DRAIN;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   assign imem_req   = w_req;
   assign imem_addr  = w_addr;
   assign ifid_valid = r_ifid_valid;
   assign ifid_pc    = r_ifid_pc;
   assign ifid_insn  = r_ifid_insn;
   assign currentpc  = r_pc;
   assign misalign   = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic              CLK = 1'b0;
   logic              reset = 1'b1;
   logic [63:0]       startpc = 64'h100;
   logic              imem_req;
   logic [63:0]       imem_addr;
   logic              imem_ack = 1'b0;
   logic [31:0]       imem_rdata = 32'h0;
   logic              redirect = 1'b0;
   logic [63:0]       redirect_pc = 64'h0;
   logic              stall = 1'b0;
   logic              ifid_valid;
   logic [63:0]       ifid_pc;
   logic [31:0]       ifid_insn;
   logic [63:0]       currentpc;
   logic              misalign;

   always #5 CLK = ~CLK;

   fetch_unit dut (
      .CLK(CLK), .reset(reset), .startpc(startpc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
      .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_insn(ifid_insn),
      .currentpc(currentpc), .misalign(misalign)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Model: next fetch address, outstanding-request bookkeeping, parked insn, IF/ID contents.
   bit          m_known = 1'b0;
   logic [63:0] m_pc;
   bit          m_wait, m_drain, m_hold, m_v, m_mis;
   logic [63:0] m_drain_addr, m_hpc, m_ipc;
   logic [31:0] m_hinsn, m_iinsn;

   logic        last_req;
   logic [63:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_00F0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // ak: 0 no ack, 1 ack, 2 random ack decided from the visible request
   task automatic step(input bit rs, input bit rd, input logic [63:0] rpc, input bit st, input int ak);
      bit          e_req, acc, a, got;
      logic [63:0] e_addr;
      @(negedge CLK);
      reset = rs; redirect = rd; redirect_pc = rpc; stall = st; imem_ack = 1'b0;
      #1;
      if (ak == 2) a = imem_req ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      else a = (ak == 1);
      imem_ack = a;
      imem_rdata = mem_word(imem_addr);
      #1;
      last_req = imem_req; last_addr = imem_addr;

      acc = !(m_v && st);
      e_addr = m_pc;
      if (rs) e_req = 1'b0;
      else if (m_drain) begin e_req = 1'b1; e_addr = m_drain_addr; end
      else if (m_wait) e_req = 1'b1;
      else if (m_hold) e_req = 1'b0;
      else e_req = acc && !rd;

      if (rs || m_known) chk("imem_req", {63'd0, imem_req}, {63'd0, e_req});
      if (m_known && !rs && e_req) chk("imem_addr", imem_addr, e_addr);
      if (m_known) begin
         chk("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_v});
         chk("currentpc", currentpc, m_pc);
         chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
         if (m_v) begin
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_insn", {32'd0, ifid_insn}, {32'd0, m_iinsn});
         end
      end

      got = e_req && a;
      if (rs) begin
         m_known = 1'b1; m_pc = startpc; m_wait = 0; m_drain = 0; m_hold = 0; m_v = 0; m_mis = 0;
      end else if (m_known) begin
         if (rd) begin
            m_mis = m_mis | (rpc[1:0] != 2'b00);
            m_pc = rpc; m_v = 0; m_hold = 0; m_wait = 0;
            m_drain = e_req && !a;
            if (m_drain) m_drain_addr = e_addr;
         end else if (m_drain) begin
            if (a) m_drain = 0;
         end else if (m_hold) begin
            if (acc) begin m_v = 1; m_ipc = m_hpc; m_iinsn = m_hinsn; m_hold = 0; end
         end else if (got) begin
            if (acc) begin m_v = 1; m_ipc = m_pc; m_iinsn = mem_word(m_pc); end
            else begin m_hold = 1; m_hpc = m_pc; m_hinsn = mem_word(m_pc); end
            m_pc = m_pc + 64'd4;
            m_wait = 0;
         end else if (e_req) begin
            m_wait = 1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [63:0] r;
      // reset and zero-wait streaming
      startpc = 64'h100;
      step(1'b1, 1'b0, 64'h0, 1'b0, 0);
      step(1'b1, 1'b0, 64'h0, 1'b0, 1);
      chk("rst_req", {63'd0, last_req}, 64'd0);
      chk("rst_valid", {63'd0, ifid_valid}, 64'd0);
      chk("rst_ifid_pc", ifid_pc, 64'h0);
      chk("rst_ifid_insn", {32'd0, ifid_insn}, 64'h0);
      chk("rst_pc", currentpc, 64'h100);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("zw_pc0", ifid_pc, 64'h100);
      chk("zw_valid", {63'd0, ifid_valid}, 64'd1);
      chk("zw_insn0", {32'd0, ifid_insn}, 64'h5A5A_01F0);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("zw_pc1", ifid_pc, 64'h104);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("zw_pc2", ifid_pc, 64'h108);

      // ack delayed three cycles
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 64'h0, 1'b0, 0);
         chk("dly_req", {63'd0, last_req}, 64'd1);
         chk("dly_addr", last_addr, 64'h10C);
      end
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("dly_ifid", ifid_pc, 64'h10C);
      chk("dly_next", currentpc, 64'h110);

      // stall while the response arrives -> parked, released in order
      step(1'b0, 1'b0, 64'h0, 1'b0, 0);
      step(1'b0, 1'b0, 64'h0, 1'b1, 1);
      chk("hold_ifid", ifid_pc, 64'h10C);
      chk("hold_pc", currentpc, 64'h114);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 64'h0, 1'b1, 0);
         chk("hold_noreq", {63'd0, last_req}, 64'd0);
         chk("hold_keep", ifid_pc, 64'h10C);
      end
      step(1'b0, 1'b0, 64'h0, 1'b0, 0);
      chk("rel_ifid", ifid_pc, 64'h110);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("rel_next", ifid_pc, 64'h114);

      // redirect during an outstanding request -> stale response discarded
      step(1'b0, 1'b0, 64'h0, 1'b0, 0);
      step(1'b0, 1'b1, 64'h200, 1'b0, 0);
      chk("rd_valid", {63'd0, ifid_valid}, 64'd0);
      chk("rd_pc", currentpc, 64'h200);
      step(1'b0, 1'b0, 64'h0, 1'b0, 0);
      chk("drain_addr", last_addr, 64'h118);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("drain_drop", {63'd0, ifid_valid}, 64'd0);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("rd_ifid", ifid_pc, 64'h200);

      // redirect together with stall
      step(1'b0, 1'b1, 64'h300, 1'b1, 1);
      chk("rdst_valid", {63'd0, ifid_valid}, 64'd0);
      chk("rdst_pc", currentpc, 64'h300);

      // misaligned target and PC wrap
      step(1'b0, 1'b1, 64'h202, 1'b0, 1);
      chk("mis_set", {63'd0, misalign}, 64'd1);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("mis_fetch", ifid_pc, 64'h202);
      step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1);
      step(1'b0, 1'b0, 64'h0, 1'b0, 1);
      chk("wrap_pc", currentpc, 64'h0);
      chk("wrap_ifid", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("mis_sticky", {63'd0, misalign}, 64'd1);
      step(1'b1, 1'b0, 64'h0, 1'b0, 1);
      chk("mis_clear", {63'd0, misalign}, 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit rs, rd, st;
         rs = ($urandom_range(96) == 0);
         if (rs) startpc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
         rd = ($urandom_range(12) == 0);
         r = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
         if ($urandom_range(7) == 0) r[1:0] = 2'($urandom_range(3));
         if ($urandom_range(15) == 0) r = 64'hFFFF_FFFF_FFFF_FFF8;
         st = ($urandom_range(2) == 0);
         step(rs, rd, r, st, 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
